// File: rtl/flash_burst_reader.sv
// rtl/flash_burst_reader.sv - burst sequencer turning spi_master 32-bit reads into a byte stream.
// Optional: define FLASH_BURST_READER_CHECKSUM_EN to add the per-burst checksum output.
module flash_burst_reader #(
  parameter int LEN_WIDTH  = 16,
  parameter int WAKE_DELAY = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [23:0]          start_addr,
  input  logic [LEN_WIDTH-1:0] byte_count,
  output logic                 busy,
  output logic                 done,
  input  logic                 spi_addr_buffer_free,
  output logic                 spi_addr_en,
  output logic [23:0]          spi_addr_data,
  input  logic                 spi_rd_data_available,
  output logic                 spi_rd_ack,
  input  logic [31:0]          spi_rd_data,
`ifdef FLASH_BURST_READER_CHECKSUM_EN
  output logic [7:0]           checksum,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data
);

  localparam int WW = (WAKE_DELAY > 1) ? $clog2(WAKE_DELAY) : 1;
  localparam logic [WW-1:0] WAKE_LAST = WW'((WAKE_DELAY > 0) ? WAKE_DELAY - 1 : 0);

  typedef enum logic [2:0] {IDLE, WAKE, REQ, WAIT_DATA, EMIT, FINISH} state_t;

  state_t               state, state_next;
  logic [23:0]          cur_addr;
  logic [LEN_WIDTH-1:0] remaining;
  logic [31:0]          word;
  logic [1:0]           idx;
  logic [WW-1:0]        wake_cnt;
  logic                 last_byte;

  assign last_byte = (remaining == LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (byte_count == '0)   state_next = FINISH;
          else if (WAKE_DELAY > 0) state_next = WAKE;
          else                     state_next = REQ;
        end
      end
      WAKE:      if (wake_cnt == WAKE_LAST) state_next = REQ;
      REQ:       if (spi_addr_buffer_free) state_next = WAIT_DATA;
      WAIT_DATA: if (spi_rd_data_available) state_next = EMIT;
      EMIT: begin
        if (out_ready) begin
          if (last_byte)        state_next = FINISH;
          else if (idx == 2'd3) state_next = REQ;
        end
      end
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr  <= '0;
      remaining <= '0;
      word      <= '0;
      idx       <= '0;
      wake_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= start_addr;
            remaining <= byte_count;
            wake_cnt  <= '0;
          end
        end
        WAKE: wake_cnt <= wake_cnt + 1'b1;
        WAIT_DATA: begin
          if (spi_rd_data_available) begin
            word <= spi_rd_data;
            idx  <= 2'd0;
          end
        end
        EMIT: begin
          if (out_ready) begin
            remaining <= remaining - 1'b1;
            idx       <= idx + 2'd1;
            // 24-bit add wraps naturally past the top of the flash map
            if (!last_byte && idx == 2'd3) cur_addr <= cur_addr + 24'd4;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FLASH_BURST_READER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)                                checksum <= '0;
    else if (state == IDLE && start)          checksum <= '0;
    else if (state == EMIT && out_ready)      checksum <= checksum + out_data;
  end
`endif

  // Pulses are gated by reset so a mid-burst reset never leaks an en/ack.
  always_comb begin
    busy          = (state != IDLE);
    done          = (state == FINISH);
    spi_addr_en   = (state == REQ) && spi_addr_buffer_free && !reset;
    spi_addr_data = cur_addr;
    spi_rd_ack    = (state == WAIT_DATA) && spi_rd_data_available && !reset;
    out_valid     = (state == EMIT);
    out_data      = 8'd0;
    if (state == EMIT) begin
      case (idx)
        2'd0:    out_data = word[31:24];
        2'd1:    out_data = word[23:16];
        2'd2:    out_data = word[15:8];
        default: out_data = word[7:0];
      endcase
    end
  end

endmodule
